// File: rtl/pipe_mips32_pkg.sv
// Shared definitions for the pipe_mips32 core.
// Contents:
//   - opcode values of the supported MIPS32 subset
//   - bit positions of the instruction fields
//   - instruction class and ALU operation enums
//   - decode helpers that map an opcode to its class and ALU operation
package pipe_mips32_pkg;

  // Register-register operations
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  // Register-immediate operations
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  // Memory, branch and halt
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Instruction field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } instr_type_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_op_e;

  // Anything not listed falls through to NOP so it never writes state.
  function automatic instr_type_e decodeType(input logic [5:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BEQZ, OP_BNEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  // Loads and stores use ADD for rs + imm address generation.
  function automatic alu_op_e decodeAluOp(input logic [5:0] opc);
    case (opc)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mips32_if.sv
// Operand/result bus between the core's EX stage and the ALU.
// Signals:
//   op - ALU operation select
//   a  - first operand
//   b  - second operand
//   y  - result
// Modports:
//   master - the pipeline; drives op/a/b and reads y
//   slave  - the ALU; computes y
interface pipe_mips32_if;
  import pipe_mips32_pkg::*;

  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] y;

  modport master (output op, output a, output b, input y);
  modport slave  (input op, input a, input b, output y);

endinterface

// File: rtl/pipe_mips32_alu.sv
// Combinational 32-bit ALU for the pipe_mips32 core.
// Ports:
//   bus - pipe_mips32_if slave
//         (op/a/b in, y out)
// Operations:
//   - SLT compares signed and yields 1 or 0.
//   - MUL keeps the low 32 bits of the product.
module mips32_alu
  import pipe_mips32_pkg::*;
(
  pipe_mips32_if.slave bus
);

  always_comb begin
    bus.y = '0;
    case (bus.op)
      ALU_ADD: bus.y = bus.a + bus.b;
      ALU_SUB: bus.y = bus.a - bus.b;
      ALU_AND: bus.y = bus.a & bus.b;
      ALU_OR:  bus.y = bus.a | bus.b;
      ALU_SLT: bus.y = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
      ALU_MUL: bus.y = bus.a * bus.b;
      default: bus.y = '0;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage (IF/ID/EX/MEM/WB) MIPS32-subset core.
// Memory and registers:
//   - Unified word-addressed memory Mem.
//   - Register file Reg.
//   - Both are left unreset so hierarchical preloads survive reset.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   halted - high once an HLT has retired; the core is then frozen
module pipe_mips32
  import pipe_mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // IF/ID
  logic        ifIdValid_q;
  logic [31:0] ifIdIr_q;
  logic [31:0] ifIdNpc_q;
  logic        fetchStop_q;

  // ID/EX
  instr_type_e idExType_q;
  alu_op_e     idExAluOp_q;
  logic        idExBeqz_q;
  logic [4:0]  idExRs_q;
  logic [4:0]  idExRt_q;
  logic [4:0]  idExDst_q;
  logic [31:0] idExA_q;
  logic [31:0] idExB_q;
  logic [31:0] idExImm_q;
  logic [31:0] idExNpc_q;

  // EX/MEM
  instr_type_e exMemType_q;
  logic        exMemWe_q;
  logic [4:0]  exMemDst_q;
  logic [31:0] exMemAlu_q;
  logic [31:0] exMemB_q;

  // MEM/WB
  instr_type_e memWbType_q;
  logic        memWbWe_q;
  logic [4:0]  memWbDst_q;
  logic [31:0] memWbAlu_q;
  logic [31:0] memWbLmd_q;

  pipe_mips32_if aluBus ();

  mips32_alu u_alu (
    .bus (aluBus.slave)
  );

  assign halted = HALTED;

  // Write-back value and enable; also used for the write-through read in ID.
  logic [31:0] wbResult;
  logic        wbWriting;
  assign wbResult  = (memWbType_q == LOAD) ? memWbLmd_q : memWbAlu_q;
  assign wbWriting = memWbWe_q && (memWbDst_q != 5'd0) && !HALTED;

  // Decode stage: field slicing and register read.
  // The read is write-through so that a same-cycle WB write is visible.
  logic [5:0]  idOpc;
  logic [4:0]  idRs;
  logic [4:0]  idRt;
  logic [4:0]  idRd;
  logic [31:0] idImm;
  instr_type_e idType;
  logic [31:0] idA;
  logic [31:0] idB;

  assign idOpc  = ifIdIr_q[OPC_HI:OPC_LO];
  assign idRs   = ifIdIr_q[RS_HI:RS_LO];
  assign idRt   = ifIdIr_q[RT_HI:RT_LO];
  assign idRd   = ifIdIr_q[RD_HI:RD_LO];
  assign idImm  = {{16{ifIdIr_q[IMM_HI]}}, ifIdIr_q[IMM_HI:IMM_LO]};
  assign idType = ifIdValid_q ? decodeType(idOpc) : NOP;

  always_comb begin
    idA = Reg[idRs];
    idB = Reg[idRt];
    if (wbWriting && memWbDst_q == idRs) idA = wbResult;
    if (wbWriting && memWbDst_q == idRt) idB = wbResult;
    if (idRs == 5'd0) idA = '0;
    if (idRt == 5'd0) idB = '0;
  end

  // EX operand forwarding.
  //   - EX/MEM wins over MEM/WB because it holds the younger producer.
  //   - A load sitting in EX/MEM has no data yet.
  //     Its consumer falls back to the older value; there is no interlock.
  logic [31:0] exA;
  logic [31:0] exB;
  logic        exMemFwdOk;
  assign exMemFwdOk = exMemWe_q && (exMemType_q != LOAD);

  always_comb begin
    exA = idExA_q;
    exB = idExB_q;
    if (idExRs_q != 5'd0) begin
      if (exMemFwdOk && exMemDst_q == idExRs_q) exA = exMemAlu_q;
      else if (memWbWe_q && memWbDst_q == idExRs_q) exA = wbResult;
    end
    if (idExRt_q != 5'd0) begin
      if (exMemFwdOk && exMemDst_q == idExRt_q) exB = exMemAlu_q;
      else if (memWbWe_q && memWbDst_q == idExRt_q) exB = wbResult;
    end
  end

  assign aluBus.op = idExAluOp_q;
  assign aluBus.a  = exA;
  assign aluBus.b  = (idExType_q == RR_ALU) ? exB : idExImm_q;

  logic        branchTaken;
  logic [31:0] branchTarget;
  assign branchTaken  = (idExType_q == BRANCH) &&
                        (idExBeqz_q ? (exA == 32'd0) : (exA != 32'd0));
  assign branchTarget = idExNpc_q + idExImm_q;

  // Front end next-state selection.
  //   - Taken branch: redirect fetch and squash the two younger stages.
  //   - HLT reaching ID: latch a sticky stop; from then on PC holds and IF feeds bubbles.
  logic [31:0] pc_d;
  logic        ifIdValid_d;
  logic [31:0] ifIdIr_d;
  logic [31:0] ifIdNpc_d;
  logic        fetchStop_d;
  logic        squashId_d;

  always_comb begin
    pc_d        = PC + 32'd1;
    ifIdValid_d = 1'b1;
    ifIdIr_d    = Mem[PC[AW-1:0]];
    ifIdNpc_d   = PC + 32'd1;
    fetchStop_d = fetchStop_q;
    squashId_d  = 1'b0;
    if (branchTaken) begin
      pc_d        = branchTarget;
      ifIdValid_d = 1'b0;
      ifIdIr_d    = '0;
      fetchStop_d = 1'b0;
      squashId_d  = 1'b1;
    end else if (fetchStop_q || idType == HALT) begin
      pc_d        = PC;
      ifIdValid_d = 1'b0;
      ifIdIr_d    = '0;
      fetchStop_d = 1'b1;
    end
  end

  // Pipeline registers, PC and status flags.
  // Once HALTED is set, nothing advances until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      fetchStop_q  <= 1'b0;
      ifIdValid_q  <= 1'b0;
      ifIdIr_q     <= '0;
      ifIdNpc_q    <= '0;
      idExType_q   <= NOP;
      idExAluOp_q  <= ALU_ADD;
      idExBeqz_q   <= 1'b0;
      idExRs_q     <= '0;
      idExRt_q     <= '0;
      idExDst_q    <= '0;
      idExA_q      <= '0;
      idExB_q      <= '0;
      idExImm_q    <= '0;
      idExNpc_q    <= '0;
      exMemType_q  <= NOP;
      exMemWe_q    <= 1'b0;
      exMemDst_q   <= '0;
      exMemAlu_q   <= '0;
      exMemB_q     <= '0;
      memWbType_q  <= NOP;
      memWbWe_q    <= 1'b0;
      memWbDst_q   <= '0;
      memWbAlu_q   <= '0;
      memWbLmd_q   <= '0;
    end else if (!HALTED) begin
      if (memWbType_q == HALT) HALTED <= 1'b1;
      TAKEN_BRANCH <= branchTaken;

      memWbType_q <= exMemType_q;
      memWbWe_q   <= exMemWe_q;
      memWbDst_q  <= exMemDst_q;
      memWbAlu_q  <= exMemAlu_q;
      memWbLmd_q  <= Mem[exMemAlu_q[AW-1:0]];

      exMemType_q <= idExType_q;
      exMemWe_q   <= (idExType_q == RR_ALU) || (idExType_q == RM_ALU) ||
                     (idExType_q == LOAD);
      exMemDst_q  <= idExDst_q;
      exMemAlu_q  <= aluBus.y;
      exMemB_q    <= exB;

      idExType_q  <= squashId_d ? NOP : idType;
      idExAluOp_q <= decodeAluOp(idOpc);
      idExBeqz_q  <= (idOpc == OP_BEQZ);
      idExRs_q    <= idRs;
      idExRt_q    <= idRt;
      idExDst_q   <= (idType == RR_ALU) ? idRd : idRt;
      idExA_q     <= idA;
      idExB_q     <= idB;
      idExImm_q   <= idImm;
      idExNpc_q   <= ifIdNpc_q;

      PC          <= pc_d;
      fetchStop_q <= fetchStop_d;
      ifIdValid_q <= ifIdValid_d;
      ifIdIr_q    <= ifIdIr_d;
      ifIdNpc_q   <= ifIdNpc_d;
    end
  end

  // Register file write port (R0 is never written).
  always_ff @(posedge clk) begin
    if (wbWriting) Reg[memWbDst_q] <= wbResult;
  end

  // Data memory write port for stores in MEM.
  always_ff @(posedge clk) begin
    if (!HALTED && exMemType_q == STORE) Mem[exMemAlu_q[AW-1:0]] <= exMemB_q;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Self-checking bench for pipe_mips32.
// ALU checks:
//   - A table of vectors drives a standalone mips32_alu through its interface.
// Program checks:
//   - Short hand-assembled programs run on the core.
//   - Registers and memory are inspected hierarchically once the core halts.
module tb_pipe_mips32;
  import pipe_mips32_pkg::*;

  // Opcodes written out independently of the design package.
  localparam logic [5:0] T_ADD   = 6'b000000;
  localparam logic [5:0] T_SUB   = 6'b000001;
  localparam logic [5:0] T_OR    = 6'b000011;
  localparam logic [5:0] T_MUL   = 6'b000101;
  localparam logic [5:0] T_LW    = 6'b001000;
  localparam logic [5:0] T_SW    = 6'b001001;
  localparam logic [5:0] T_ADDI  = 6'b001010;
  localparam logic [5:0] T_SUBI  = 6'b001011;
  localparam logic [5:0] T_BNEQZ = 6'b001101;
  localparam logic [5:0] T_BEQZ  = 6'b001110;
  localparam logic [5:0] T_HLT   = 6'b111111;

  logic clk = 1'b0;
  logic rst_n;
  logic halted;
  int   compared = 0;
  int   mismatched = 0;

  pipe_mips32 #(.MEM_DEPTH(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  pipe_mips32_if aluBus ();

  mips32_alu u_alu (
    .bus (aluBus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } aluVec_t;

  aluVec_t     vecs [9];
  logic [31:0] prog [$];

  function automatic logic [31:0] encR(input logic [5:0] op, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0];
    s = rs[4:0];
    t = rt[4:0];
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [4:0]  s, t;
    logic [15:0] i16;
    s   = rs[4:0];
    t   = rt[4:0];
    i16 = imm[15:0];
    return {op, s, t, i16};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // Hold reset, clear the low memory image, preload Reg[k]=k and place prog at address 0.
  task automatic applyStimulus();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 128; i++) dut.Mem[i] = 32'h0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runToHalt(input int budget, output int branches);
    branches = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (dut.TAKEN_BRANCH) branches++;
      if (halted) break;
    end
    checkOutput("halt reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic loadDependentAdds();
    prog = {};
    prog.push_back(encI(T_ADDI, 1, 0, 10));
    prog.push_back(encI(T_ADDI, 2, 0, 20));
    prog.push_back(encI(T_ADDI, 3, 0, 25));
    prog.push_back(encR(T_OR, 7, 7, 7));
    prog.push_back(encR(T_OR, 7, 7, 7));
    prog.push_back(encR(T_ADD, 4, 1, 2));
    prog.push_back(encR(T_OR, 7, 7, 7));
    prog.push_back(encR(T_ADD, 5, 4, 3));
    prog.push_back({T_HLT, 26'd0});
  endtask

  task automatic checkDependentAdds(input string tag);
    checkOutput({tag, " R1"}, dut.Reg[1], 32'd10);
    checkOutput({tag, " R2"}, dut.Reg[2], 32'd20);
    checkOutput({tag, " R3"}, dut.Reg[3], 32'd25);
    checkOutput({tag, " R4"}, dut.Reg[4], 32'd30);
    checkOutput({tag, " R5"}, dut.Reg[5], 32'd55);
    checkOutput({tag, " R7"}, dut.Reg[7], 32'd7);
  endtask

  initial begin
    int branches;
    int lowCycles;
    rst_n = 1'b0;

    // ALU table
    vecs[0] = '{ALU_ADD, 32'd7,         32'd5,         32'd12};
    vecs[1] = '{ALU_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE};
    vecs[2] = '{ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
    vecs[3] = '{ALU_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};
    vecs[4] = '{ALU_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[5] = '{ALU_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vecs[6] = '{ALU_SLT, 32'd3,         32'd3,         32'd0};
    vecs[7] = '{ALU_MUL, 32'd7,         32'd720,       32'd5040};
    vecs[8] = '{ALU_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000};
    for (int i = 0; i < 9; i++) begin
      aluBus.op = vecs[i].op;
      aluBus.a  = vecs[i].a;
      aluBus.b  = vecs[i].b;
      #1;
      checkOutput($sformatf("alu vec %0d", i), aluBus.y, vecs[i].y);
    end

    // Dependent adds, plus the reset state
    loadDependentAdds();
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("reset PC", dut.PC, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset TAKEN_BRANCH", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    releaseReset();
    runToHalt(200, branches);
    checkDependentAdds("deps");

    // Back-to-back forwarding; a taken BEQZ squashes an HLT sitting in ID
    prog = {};
    prog.push_back(encI(T_ADDI, 1, 0, 5));
    prog.push_back(encR(T_ADD, 2, 1, 1));
    prog.push_back(encR(T_SUB, 3, 2, 1));
    prog.push_back(encI(T_BEQZ, 0, 0, 1));
    prog.push_back({T_HLT, 26'd0});
    prog.push_back(encI(T_ADDI, 8, 0, 42));
    prog.push_back({T_HLT, 26'd0});
    applyStimulus();
    releaseReset();
    runToHalt(200, branches);
    checkOutput("fwd R2", dut.Reg[2], 32'd10);
    checkOutput("fwd R3", dut.Reg[3], 32'd5);
    checkOutput("beqz squashes HLT R8", dut.Reg[8], 32'd42);
    checkOutput("beqz pulses", branches, 32'd1);

    // Load/store, then a deliberate load-use pair that must see the stale value
    prog = {};
    prog.push_back(encI(T_ADDI, 1, 0, 120));
    prog.push_back(encI(T_LW, 2, 1, 0));
    prog.push_back(encR(T_OR, 7, 7, 7));
    prog.push_back(encI(T_ADDI, 2, 2, 45));
    prog.push_back(encI(T_SW, 2, 1, 1));
    prog.push_back(encI(T_LW, 4, 1, 0));
    prog.push_back(encI(T_ADDI, 5, 4, 1));
    prog.push_back({T_HLT, 26'd0});
    applyStimulus();
    dut.Mem[120] = 32'd85;
    dut.Mem[121] = 32'd0;
    releaseReset();
    runToHalt(200, branches);
    checkOutput("ldst Mem[121]", dut.Mem[121], 32'd130);
    checkOutput("ldst R2", dut.Reg[2], 32'd130);
    checkOutput("ldst R4", dut.Reg[4], 32'd85);
    checkOutput("load-use stale R5", dut.Reg[5], 32'd5);

    // Factorial of 7; R13/R14 after the branch must bump exactly once
    prog = {};
    prog.push_back(encI(T_ADDI, 10, 0, 7));
    prog.push_back(encI(T_ADDI, 11, 0, 1));
    prog.push_back(encR(T_MUL, 11, 11, 10));
    prog.push_back(encI(T_SUBI, 10, 10, 1));
    prog.push_back(encI(T_BNEQZ, 0, 10, -3));
    prog.push_back(encI(T_ADDI, 13, 13, 1));
    prog.push_back(encI(T_ADDI, 14, 14, 1));
    prog.push_back({T_HLT, 26'd0});
    applyStimulus();
    releaseReset();
    runToHalt(400, branches);
    checkOutput("fact R11", dut.Reg[11], 32'd5040);
    checkOutput("fact R10", dut.Reg[10], 32'd0);
    checkOutput("fact shadow R13", dut.Reg[13], 32'd14);
    checkOutput("fact shadow R14", dut.Reg[14], 32'd15);
    checkOutput("fact taken pulses", branches, 32'd6);

    // Halt freeze: the ADDI after HLT must never run
    prog = {};
    prog.push_back({T_HLT, 26'd0});
    prog.push_back(encI(T_ADDI, 9, 0, 1));
    applyStimulus();
    releaseReset();
    runToHalt(100, branches);
    lowCycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!halted) lowCycles++;
    end
    checkOutput("freeze halted low cycles", lowCycles, 32'd0);
    checkOutput("freeze PC", dut.PC, 32'd1);
    checkOutput("freeze R9", dut.Reg[9], 32'd9);

    // Reset mid-run, then the same program completes normally
    loadDependentAdds();
    applyStimulus();
    releaseReset();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset PC", dut.PC, 32'd0);
    checkOutput("midreset halted", {31'd0, halted}, 32'd0);
    checkOutput("midreset TAKEN_BRANCH", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    releaseReset();
    runToHalt(200, branches);
    checkDependentAdds("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_mips32.md
Name: pipe_mips32

Overview:
- Five-stage (IF, ID, EX, MEM, WB) pipelined MIPS32-subset processor core with a unified internal word-addressed instruction/data memory and a 32x32 register file.
- Runs from PC=0 after reset until an HLT instruction retires, then freezes.
- Used as the top-level CPU core in processor-level simulation; software preloads Mem and Reg hierarchically.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the unified memory (word addressed).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- halted  output  1  mirrors internal HALTED flag.

Behaviour:
- Hierarchically visible state, names fixed: Reg[0:31] (32-bit), Mem[0:MEM_DEPTH-1] (32-bit), PC, HALTED, TAKEN_BRANCH.
- Reset (rst_n low): PC=0, HALTED=0, TAKEN_BRANCH=0, all pipeline registers hold bubbles (no write enables).
- Reg and Mem are not reset, so bench preloads survive.
- Encoding:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
  - imm [15:0] is sign-extended to 32 bits.
- RR ops (rd <= rs op rt): ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101 (low 32 bits).
- RM ops (rt <= rs op imm): ADDI 001010, SUBI 001011, SLTI 001100. SLT/SLTI are signed and produce 1 or 0.
- Memory ops:
  - LW 001000: rt <= Mem[rs+imm].
  - SW 001001: Mem[rs+imm] <= rt.
  - Address uses the low log2(MEM_DEPTH) bits.
- Branches: BEQZ 001110 and BNEQZ 001101 test rs against zero. Target = branch PC + 1 + imm.
- HLT: 111111.
- Unlisted opcodes execute as NOPs (no writes).
- Timing for an instruction fetched at edge n: ID n+1, EX n+2, MEM n+3, WB n+4. Throughput is one instruction per cycle.
- R0 reads as 0; writes to R0 are ignored.
- Hazards and forwarding:
  - Register file is write-through: a WB write is visible to an ID read in the same cycle.
  - EX operands forward from EX/MEM (ALU result), then from MEM/WB (ALU or load result). The younger producer wins.
  - Result: an RR/RM result is usable by the very next instruction.
  - No load-use interlock. Software must place at least one instruction between an LW and its consumer; otherwise the consumer gets the stale value.
- Branch handling:
  - Resolved in EX using the forwarded rs.
  - If taken: PC <= target at that edge, TAKEN_BRANCH=1 for one cycle, and IF/ID and ID/EX are squashed to bubbles.
  - Penalty is two cycles; there is no delay slot.
  - A not-taken branch costs nothing.
- Halt handling:
  - When HLT is in ID, fetch stops: PC holds and IF injects bubbles.
  - When HLT reaches WB, HALTED=1. From then on the pipeline is frozen, with no Reg/Mem writes and no PC change, until reset.
- Simultaneous events:
  - A taken branch in EX squashes an HLT sitting in ID; fetch resumes at the branch target.
  - Reset mid-operation aborts all in-flight instructions; writes already performed persist.

Decomposition:
- Package pipe_mips32_pkg holds:
  - opcode localparams;
  - instruction-type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP);
  - field-slice constants.
- Natural sub-module: mips32_alu (combinational; op select, two 32-bit operands, 32-bit result).
- Register file, memory and pipeline registers stay in the top level so the hierarchical names remain exact.

Test Plan:
- Dependent adds: preload Reg[k]=k, then run ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; OR R7,R7,R7 x2; ADD R4,R1,R2; OR R7,R7,R7; ADD R5,R4,R3; HLT. Required: R1=10, R2=20, R3=25, R4=30, R5=55, halted=1.
- Back-to-back forwarding: run ADDI R1,R0,5; ADD R2,R1,R1; SUB R3,R2,R1; HLT. Required: R2=10, R3=5.
- Load/store: set Mem[120]=85, then run ADDI R1,R0,120; LW R2,0(R1); OR R7,R7,R7; ADDI R2,R2,45; SW R2,1(R1); HLT. Required: Mem[121]=130.
- Loop: compute factorial with MUL/SUBI/BNEQZ for n=7. Required: result 5040; instructions after a taken branch never write.
- Halt freeze: place HLT followed by ADDI R9,R0,1. Required: R9 unchanged, PC frozen, and halted stays 1 for 20 further cycles.
- Reset mid-run: assert rst_n low after 3 instructions, then release. Required: PC restarts at 0, HALTED=0, and the program completes with the same final values as an uninterrupted run.
